// File: rtl/stereo_pkg.sv
// Shared constants and helpers for the scanline stereo disparity engine.
package stereo_pkg;

  localparam int              PIX_W    = 4;
  localparam logic [PIX_W-1:0] COST_MAX = 4'd15;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width that holds a full window of worst-case pixel costs.
  function automatic int sum_width(input int win);
    return clog2(int'(COST_MAX) * win + 1);
  endfunction

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/disp_argmin_tree.sv
// Pipelined winner-take-all reduction over N (cost, index) pairs, one register per level.
// Ties resolve to the lower index; result registers hold the last valid winner.
module disp_argmin_tree
  import stereo_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int SW = 7,
  localparam int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [SW-1:0] cost [N],
  output logic          win_valid,
  output logic [IW-1:0] win_idx,
  output logic [SW-1:0] win_cost
);

  for (genvar l = 0; l <= IW; l++) begin : g_lvl
    localparam int NL = N >> l;
    logic          lv_valid;
    logic [SW-1:0] lv_cost [NL];
    logic [IW-1:0] lv_idx  [NL];

    if (l == 0) begin : g_leaf
      assign lv_valid = valid;
      for (genvar i = 0; i < N; i++) begin : g_in
        assign lv_cost[i] = cost[i];
        assign lv_idx[i]  = IW'(i);
      end
    end else begin : g_node
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lv_valid <= 1'b0;
          for (int i = 0; i < NL; i++) begin
            lv_cost[i] <= '0;
            lv_idx[i]  <= '0;
          end
        end else begin
          lv_valid <= g_lvl[l-1].lv_valid;
          if (g_lvl[l-1].lv_valid) begin
            for (int i = 0; i < NL; i++) begin
              // Strict less-than: the even (lower-index) side keeps ties.
              if (g_lvl[l-1].lv_cost[2*i+1] < g_lvl[l-1].lv_cost[2*i]) begin
                lv_cost[i] <= g_lvl[l-1].lv_cost[2*i+1];
                lv_idx[i]  <= g_lvl[l-1].lv_idx[2*i+1];
              end else begin
                lv_cost[i] <= g_lvl[l-1].lv_cost[2*i];
                lv_idx[i]  <= g_lvl[l-1].lv_idx[2*i];
              end
            end
          end
        end
      end
    end
  end

  assign win_valid = g_lvl[IW].lv_valid;
  assign win_idx   = g_lvl[IW].lv_idx[0];
  assign win_cost  = g_lvl[IW].lv_cost[0];

endmodule

// File: rtl/stereo_disparity_wta.sv
// Scanline SAD block matcher: right-pixel shift register, absolute-difference stage,
// per-disparity running window sums and a pipelined argmin, fixed latency 3+clog2(MAX_DISP).
module stereo_disparity_wta
  import stereo_pkg::*;
#(
  parameter  int MAX_DISP = 16,
  parameter  int WIN      = 5,
  localparam int DW       = clog2(MAX_DISP),
  localparam int SW       = sum_width(WIN)
) (
  input  logic             clk25,
  input  logic             nreset,
  input  logic             vsync,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_l,
  input  logic [PIX_W-1:0] pix_r,
  output logic             disp_valid,
  output logic [DW-1:0]    disp,
  output logic [PIX_W-1:0] disp_pix,
  output logic [SW-1:0]    min_cost
);

  localparam int CW = clog2(MAX_DISP + 1);

  // A pixel is accepted only outside frame clear; a rise of that marks x=0 of a new line.
  logic in_valid, prev_valid, line_start;
  assign in_valid   = pix_valid & vsync;
  assign line_start = in_valid & ~prev_valid;

  // Stage S1
  logic             s1_valid, s1_first;
  logic [PIX_W-1:0] s1_l;
  logic [CW-1:0]    col;
  logic [PIX_W-1:0] rsh [MAX_DISP];

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // predecessor's pre-edge value regardless of statement order.
  // NOTE: the right-pixel and cost delay lines are small flop arrays, so they are reset;
  // a RAM-based line buffer would not be.
  always_ff @(posedge clk25 or negedge nreset) begin
    if (!nreset) begin
      prev_valid <= 1'b0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_l       <= '0;
      col        <= '0;
      rsh        <= '{default: '0};
    end else begin
      prev_valid <= in_valid;
      s1_valid   <= in_valid;
      s1_first   <= line_start;
      if (in_valid) s1_l <= pix_l;
      if (!vsync) begin
        col <= '0;
        rsh <= '{default: '0};
      end else if (in_valid) begin
        col    <= line_start ? '0 : ((col == CW'(MAX_DISP)) ? col : col + 1'b1);
        rsh[0] <= pix_r;
        for (int d = 1; d < MAX_DISP; d++)
          rsh[d] <= line_start ? '0 : rsh[d-1];
      end
    end
  end

  // Stage S2: per-disparity absolute difference, forced to the maximum before R(x-d) exists.
  logic             s2_valid, s2_first;
  logic [PIX_W-1:0] s2_cost [MAX_DISP];

  always_ff @(posedge clk25 or negedge nreset) begin
    if (!nreset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_cost  <= '{default: '0};
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      if (s1_valid) begin
        for (int d = 0; d < MAX_DISP; d++)
          s2_cost[d] <= (int'(col) < d) ? COST_MAX : abs_diff(s1_l, rsh[d]);
      end
    end
  end

  // Stage S3: trailing-window sums; modulo-2^SW arithmetic is exact since sums fit in SW.
  logic             s3_valid;
  logic [SW-1:0]    sum [MAX_DISP];
  logic [PIX_W-1:0] dly [MAX_DISP][WIN];

  always_ff @(posedge clk25 or negedge nreset) begin
    if (!nreset) begin
      s3_valid <= 1'b0;
      sum      <= '{default: '0};
      dly      <= '{default: '{default: '0}};
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        for (int d = 0; d < MAX_DISP; d++) begin
          dly[d][0] <= s2_cost[d];
          if (s2_first) begin
            sum[d] <= SW'(s2_cost[d]);
            for (int k = 1; k < WIN; k++) dly[d][k] <= '0;
          end else begin
            sum[d] <= sum[d] + SW'(s2_cost[d]) - SW'(dly[d][WIN-1]);
            for (int k = 1; k < WIN; k++) dly[d][k] <= dly[d][k-1];
          end
        end
      end
    end
  end

  disp_argmin_tree #(
    .N  (MAX_DISP),
    .SW (SW)
  ) u_argmin (
    .clk       (clk25),
    .rst_n     (nreset),
    .valid     (s3_valid),
    .cost      (sum),
    .win_valid (disp_valid),
    .win_idx   (disp),
    .win_cost  (min_cost)
  );

  if (DW <= PIX_W) begin : g_pix_up
    assign disp_pix = PIX_W'(disp) << (PIX_W - DW);
  end else begin : g_pix_down
    assign disp_pix = disp[DW-1 -: PIX_W];
  end

endmodule

// File: tb/tb_stereo_disparity_wta.sv
// Scoreboard bench: a direct SAD/argmin line model predicts each pixel's result at drive time.
module tb_stereo_disparity_wta;

  localparam int MAX_DISP = 16;
  localparam int WIN      = 5;
  localparam int DW       = 4;
  localparam int SW       = 7;
  localparam int LAT      = 7;

  logic          clk25 = 1'b0;
  logic          nreset;
  logic          vsync;
  logic          pix_valid;
  logic [3:0]    pix_l, pix_r;
  logic          disp_valid;
  logic [DW-1:0] disp;
  logic [3:0]    disp_pix;
  logic [SW-1:0] min_cost;

  stereo_disparity_wta #(.MAX_DISP(MAX_DISP), .WIN(WIN)) dut (
    .clk25      (clk25),
    .nreset     (nreset),
    .vsync      (vsync),
    .pix_valid  (pix_valid),
    .pix_l      (pix_l),
    .pix_r      (pix_r),
    .disp_valid (disp_valid),
    .disp       (disp),
    .disp_pix   (disp_pix),
    .min_cost   (min_cost)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    int disp;
    int cost;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ml [0:255];
  int   mr [0:255];
  int   m_x      = 0;
  bit   m_prev   = 1'b0;
  int   hold_disp = 0;
  int   hold_cost = 0;
  int   dv_count  = 0;
  bit   prev_dv   = 1'b0;
  bit   rise_arm  = 1'b0;
  int   rise_cyc  = -1;
  int   tex [0:127];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int pix_of(input int d);
    if (DW <= 4) return (d << (4 - DW)) & 15;
    else         return (d >> (DW - 4)) & 15;
  endfunction

  // Window SAD for every candidate at column x of the current model line, lowest cost wins.
  function automatic exp_t model(input int x);
    exp_t r;
    int   lo, s, c;
    r.disp = 0;
    r.cost = 1 << 30;
    lo = (x - WIN + 1 < 0) ? 0 : x - WIN + 1;
    for (int d = 0; d < MAX_DISP; d++) begin
      s = 0;
      for (int j = lo; j <= x; j++) begin
        c = (j < d) ? 15 : absd(ml[j], mr[j-d]);
        s += c;
      end
      if (s < r.cost) begin
        r.cost = s;
        r.disp = d;
      end
    end
    return r;
  endfunction

  task automatic drive(input int l, input int r);
    if (!m_prev) m_x = 0;
    ml[m_x] = l;
    mr[m_x] = r;
    sb.push_back(model(m_x));
    m_x++;
    m_prev    = 1'b1;
    vsync     = 1'b1;
    pix_valid = 1'b1;
    pix_l     = 4'(l);
    pix_r     = 4'(r);
    @(negedge clk25);
  endtask

  task automatic idle(input int n);
    vsync     = 1'b1;
    pix_valid = 1'b0;
    m_prev    = 1'b0;
    repeat (n) @(negedge clk25);
  endtask

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (nreset) begin
      if (disp_valid) begin
        dv_count++;
        if (!prev_dv && rise_arm) begin
          rise_cyc = cyc;
          rise_arm = 1'b0;
        end
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("disp", int'(disp), e.disp);
          check("min_cost", int'(min_cost), e.cost);
          check("disp_pix", int'(disp_pix), pix_of(e.disp));
          hold_disp = e.disp;
          hold_cost = e.cost;
        end
      end else begin
        check("hold_disp", int'(disp), hold_disp);
        check("hold_cost", int'(min_cost), hold_cost);
      end
    end
    prev_dv = disp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int t0;
    int lt [6];
    int rt [6];
    lt = '{9, 9, 9, 2, 8, 1};
    rt = '{9, 9, 3, 9, 9, 6};
    for (int i = 0; i < 128; i++) tex[i] = $urandom_range(0, 15);

    nreset = 1'b0; vsync = 1'b1; pix_valid = 1'b0; pix_l = '0; pix_r = '0;
    repeat (3) @(negedge clk25);
    check("rst_disp_valid", int'(disp_valid), 0);
    check("rst_disp", int'(disp), 0);
    check("rst_disp_pix", int'(disp_pix), 0);
    check("rst_min_cost", int'(min_cost), 0);
    nreset = 1'b1;
    idle(3);

    // Equal lines, plus first-pixel latency.
    t0 = cyc;
    rise_arm = 1'b1;
    for (int x = 0; x < 64; x++) drive(7, 7);
    idle(12);
    check("latency", rise_cyc - t0, LAT);
    check("drain_equal", sb.size(), 0);

    // Right image shifted by 3.
    for (int x = 0; x < 64; x++) drive(tex[x], tex[x+3]);
    idle(12);

    // Left edge with partial candidate set.
    for (int x = 0; x < 6; x++) drive(lt[x], rt[x]);
    idle(12);

    // Flat line: all costs tie, lowest index wins.
    for (int x = 0; x < 24; x++) drive(5, 5);
    idle(12);

    // Gap of two cycles at x=30 restarts the line.
    for (int x = 0; x < 30; x++) drive(tex[x], tex[x+3]);
    idle(2);
    for (int x = 30; x < 50; x++) drive(tex[x], tex[x+3]);
    idle(12);
    check("drain_gap", sb.size(), 0);

    // Asynchronous reset mid-line.
    for (int x = 0; x < 10; x++) drive(tex[x], tex[x+3]);
    #2;
    nreset    = 1'b0;
    pix_valid = 1'b0;
    m_prev    = 1'b0;
    sb.delete();
    hold_disp = 0;
    hold_cost = 0;
    #1;
    check("midrst_disp_valid", int'(disp_valid), 0);
    check("midrst_disp", int'(disp), 0);
    check("midrst_min_cost", int'(min_cost), 0);
    @(negedge clk25);
    repeat (2) @(negedge clk25);
    nreset = 1'b1;
    for (int x = 0; x < 20; x++) drive(tex[x+40], tex[x+43]);
    idle(12);

    // Frame clear with pix_valid held high, then the line resumes as x=0.
    dv_count  = 0;
    vsync     = 1'b0;
    pix_valid = 1'b1;
    m_prev    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_l = 4'($urandom_range(0, 15));
      pix_r = 4'($urandom_range(0, 15));
      @(negedge clk25);
    end
    for (int x = 0; x < 12; x++) drive(tex[x+60], tex[x+63]);
    idle(15);
    check("vsync_pulses", dv_count, 12);
    check("drain_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
